sig_field_unpack: RTL and testbench
===================================

# sig_field_unpack

Registered, multi-channel successor to the plain static bus breakout. It extracts CH independently configurable bit fields from a wide input word and presents each one right-aligned and zero-filled on its own OW-bit lane. Input and output use a valid/ready handshake, and field positions are run-time programmable. It sits between a wishbone-side status/data word and the per-signal consumers (LED drivers, button/IR decode, etc.). Field positions can be re-mapped without resynthesis.

## Interface
Parameters:
- IW, 32: input bus width, 1..256.
- OW, 8: width of each output field lane, 1..IW.
- CH, 4: number of channels, 1..16.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_sel  in  4  channel index to configure.
- cfg_lsb  in  8  field start bit in i_bus.
- cfg_len  in  8  field length in bits.
- i_valid  in  1  input word valid.
- i_ready  out  1  block can accept a word.
- i_bus  in  IW  input word.
- o_valid  out  1  output lanes valid.
- o_ready  in  1  consumer accepts the output.
- o_sig  out  CH*OW  lane c occupies bits [c*OW+OW-1 : c*OW].

## Operation
- Per-channel config registers hold lsb[c] and len[c].
  - Reset values: lsb[c] = c*OW and len[c] = OW, which gives an identity breakout.
- A config write with cfg_we=1 and cfg_sel<CH updates channel cfg_sel at the edge.
  - If cfg_sel≥CH, the write is ignored.
  - cfg_len is clamped to OW when stored; the stored value is min(cfg_len, OW).
- Field extraction for lane c:
  - Bit k of the lane, for k<len[c], takes i_bus[lsb[c]+k].
  - A source bit index ≥IW reads as 0.
  - Lane bits k≥len[c] read as 0.
  - len[c]=0 gives an all-zero lane.
  - Index arithmetic is 9 bits wide, so lsb+k never wraps.
- Output stage is one register holding o_sig and o_valid.
  - i_ready = !o_valid || o_ready, combinational.
  - On accept (i_valid && i_ready), the extracted lanes are loaded and o_valid=1.
  - If o_valid && o_ready with no accept, o_valid clears. o_sig holds its last value.
  - When the register is full and o_ready=0, o_sig and o_valid stay stable. i_bus is not sampled.
- Outputs after reset: o_valid=0, o_sig=0, i_ready=1.

## Timing
- Latency is 1 cycle: a word accepted at edge N is on o_sig with o_valid=1 after edge N.
- Throughput is one word per cycle while o_ready=1.
- Config write and accept in the same cycle: the accepted word uses the pre-write config. The new config applies from the next accepted word.
- A word already held in the output register is never altered by later config writes.
- Reset mid-transfer:
  - The held word is discarded and o_valid=0 after the edge.
  - Config returns to defaults.
  - rst overrides cfg_we and accept in the same cycle.
- o_valid never drops without o_ready=1, and o_sig never changes while o_valid && !o_ready.

## Configuration
- Macro: SIG_FIELD_UNPACK_SIGNEXT_EN.
- Defined:
  - Each channel gains a sign flag, written from cfg_len[7]. The length is taken from cfg_len[6:0], then clamped.
  - When the sign flag is set and len[c]>0, lane bits k≥len[c] are copied from lane bit len[c]-1.
  - Sign flags reset to 0.
- Not defined:
  - cfg_len[7] is treated as an ordinary length bit and is clamped like any other length value.
  - All lanes are zero-filled.
  - No sign registers exist.

## Test plan
- Defaults, IW=32, OW=8, CH=4: i_bus=0xA1B2C3D4, o_ready=1 → next cycle o_sig=0xA1B2C3D4, o_valid=1.
- Write ch0 lsb=28, len=8, then send i_bus=0xF0000000 → lane0=0x0F. Bits 32..35 read 0.
- Write ch1 len=0; write ch2 len=20 (clamps to 8); write cfg_sel=9 (ignored) → lane1=0x00, lane2 is 8 bits wide, ch3 is unchanged.
- Backpressure: o_ready=0 for 3 cycles with i_valid=1 → i_ready=0 and o_sig stable. Raise o_ready → the pending word is accepted on the same edge the held word drains, with no loss and no duplicate.
- Same-cycle cfg write of ch0 lsb=4 and accept of 0x000000F0 → lane0=0xF0 (old mapping). The next 0x000000F0 gives lane0=0x0F.
- With SIG_FIELD_UNPACK_SIGNEXT_EN: ch0 lsb=0, cfg_len=0x84 (signed, len 4), i_bus=0x0000000A → lane0=0xFA. Assert rst mid-hold → o_valid=0 and the defaults are restored.

Source files
------------

// File: rtl/sig_field_unpack_if.sv
// rtl/sig_field_unpack_if.sv - config, input-word and output-lane signals of sig_field_unpack
interface sig_field_unpack_if #(
    parameter int IW = 32,
    parameter int OW = 8,
    parameter int CH = 4
);
    logic             cfg_we;
    logic [3:0]       cfg_sel;
    logic [7:0]       cfg_lsb;
    logic [7:0]       cfg_len;
    logic             i_valid;
    logic             i_ready;
    logic [IW-1:0]    i_bus;
    logic             o_valid;
    logic             o_ready;
    logic [CH*OW-1:0] o_sig;

    modport master (
        output cfg_we, cfg_sel, cfg_lsb, cfg_len,
        output i_valid, i_bus, o_ready,
        input  i_ready, o_valid, o_sig
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_lsb, cfg_len,
        input  i_valid, i_bus, o_ready,
        output i_ready, o_valid, o_sig
    );
endinterface

// File: rtl/sig_field_unpack.sv
// rtl/sig_field_unpack.sv - registered, run-time programmable bit-field breakout onto CH lanes
// Optional SIG_FIELD_UNPACK_SIGNEXT_EN adds a per-channel sign-extension flag.
module sig_field_unpack #(
    parameter int IW = 32,
    parameter int OW = 8,
    parameter int CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    sig_field_unpack_if.slave bus
);
    localparam logic [8:0] OW9 = 9'(OW);
    localparam logic [4:0] CH5 = 5'(CH);
    localparam int         XW  = 512;

    logic [7:0]       lsb_q [CH];
    logic [8:0]       len_q [CH];
`ifdef SIG_FIELD_UNPACK_SIGNEXT_EN
    logic [CH-1:0]    sign_q;
`endif

    logic [XW-1:0]    bus_ext;
    logic [CH*OW-1:0] lanes;
    logic             cfg_hit;
    logic [8:0]       cfg_len_raw;
    logic [8:0]       cfg_len_clamped;
    logic             accept;
    logic             o_valid_q;
    logic [CH*OW-1:0] o_sig_q;

    // Identity breakout; offsets past the 8-bit lsb range saturate.
    function automatic logic [7:0] default_lsb(input int c);
        return (c * OW > 255) ? 8'd255 : 8'(c * OW);
    endfunction

    // Zero-padding to 512 bits makes every 9-bit source index legal and reads 0 above IW.
    assign bus_ext = {{(XW-IW){1'b0}}, bus.i_bus};
    assign cfg_hit = bus.cfg_we && ({1'b0, bus.cfg_sel} < CH5);

    always_comb begin
        cfg_len_raw = 9'd0;
`ifdef SIG_FIELD_UNPACK_SIGNEXT_EN
        cfg_len_raw = {2'b00, bus.cfg_len[6:0]};
`else
        cfg_len_raw = {1'b0, bus.cfg_len};
`endif
        cfg_len_clamped = (cfg_len_raw > OW9) ? OW9 : cfg_len_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                lsb_q[c] <= default_lsb(c);
                len_q[c] <= OW9;
            end
`ifdef SIG_FIELD_UNPACK_SIGNEXT_EN
            sign_q <= '0;
`endif
        end else if (cfg_hit) begin
            for (int c = 0; c < CH; c++) begin
                if (bus.cfg_sel == 4'(c)) begin
                    lsb_q[c] <= bus.cfg_lsb;
                    len_q[c] <= cfg_len_clamped;
`ifdef SIG_FIELD_UNPACK_SIGNEXT_EN
                    sign_q[c] <= bus.cfg_len[7];
`endif
                end
            end
        end
    end

    always_comb begin
        lanes = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < OW; k++) begin
                if (9'(k) < len_q[c]) begin
                    lanes[c*OW + k] = bus_ext[{1'b0, lsb_q[c]} + 9'(k)];
                end
            end
`ifdef SIG_FIELD_UNPACK_SIGNEXT_EN
            // Upper lane bits replicate the field's top bit, i.e. source bit lsb+len-1.
            if (sign_q[c] && (len_q[c] != 9'd0)) begin
                for (int k = 0; k < OW; k++) begin
                    if (9'(k) >= len_q[c]) begin
                        lanes[c*OW + k] = bus_ext[{1'b0, lsb_q[c]} + len_q[c] - 9'd1];
                    end
                end
            end
`endif
        end
    end

    assign bus.i_ready = !o_valid_q || bus.o_ready;
    assign accept      = bus.i_valid && bus.i_ready;

    // Lanes are captured with the config in force before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_sig_q   <= '0;
        end else if (accept) begin
            o_valid_q <= 1'b1;
            o_sig_q   <= lanes;
        end else if (o_valid_q && bus.o_ready) begin
            o_valid_q <= 1'b0;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_sig   = o_sig_q;
endmodule

// File: tb/tb_sig_field_unpack.sv
// tb/tb_sig_field_unpack.sv - vector table, directed sequences and random run for sig_field_unpack
module tb_sig_field_unpack;
    localparam int IW = 32;
    localparam int OW = 8;
    localparam int CH = 4;
`ifdef SIG_FIELD_UNPACK_SIGNEXT_EN
    localparam bit SX = 1'b1;
`else
    localparam bit SX = 1'b0;
`endif

    logic clk;
    logic rst;

    sig_field_unpack_if #(.IW(IW), .OW(OW), .CH(CH)) bus_if ();

    sig_field_unpack #(.IW(IW), .OW(OW), .CH(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_lsb  [CH];
    int          m_len  [CH];
    bit          m_sign [CH];
    bit          m_valid;
    logic [31:0] m_sig;
    logic [31:0] exp_q [$];

    typedef struct {
        bit          r;
        bit          we;
        int          sel;
        int          lsb;
        int          len;
        bit          iv;
        logic [31:0] w;
        bit          ordy;
        bit          ev;
        logic [31:0] es;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_lane(input logic [31:0] w, input int lsb, input int len, input bit sgn);
        logic [63:0] v;
        logic [63:0] mask;
        v    = {32'd0, w} >> lsb;
        mask = (64'd1 << len) - 64'd1;
        v    = v & mask;
        if (sgn && len > 0 && v[len-1]) v = v | ~mask;
        return v[7:0];
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c*OW +: OW] = ref_lane(w, m_lsb[c], m_len[c], m_sign[c]);
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_lsb[c]  = c * OW;
            m_len[c]  = OW;
            m_sign[c] = 1'b0;
        end
        m_valid = 1'b0;
        m_sig   = '0;
        exp_q.delete();
    endtask

    task automatic cycle(input bit r, input bit we, input int sel, input int lsb, input int len,
                         input bit iv, input logic [31:0] w, input bit ordy);
        bit          acc;
        int          l;
        logic [31:0] d;
        rst            = r;
        bus_if.cfg_we  = we;
        bus_if.cfg_sel = 4'(sel);
        bus_if.cfg_lsb = 8'(lsb);
        bus_if.cfg_len = 8'(len);
        bus_if.i_valid = iv;
        bus_if.i_bus   = w;
        bus_if.o_ready = ordy;
        #2;
        check("i_ready", {63'd0, bus_if.i_ready}, {63'd0, (!m_valid || ordy)});
        if (bus_if.o_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("delivery_extra", 64'd1, 64'd0);
            end else begin
                d = exp_q.pop_front();
                check("delivery", {32'd0, bus_if.o_sig}, {32'd0, d});
            end
        end
        acc = iv && (!m_valid || ordy);
        if (r) begin
            model_reset();
        end else begin
            if (acc) begin
                m_sig   = ref_word(w);
                m_valid = 1'b1;
                exp_q.push_back(m_sig);
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
            if (we && sel < CH) begin
                l           = SX ? (len & 127) : (len & 255);
                m_lsb[sel]  = lsb & 255;
                m_len[sel]  = (l > OW) ? OW : l;
                m_sign[sel] = SX ? ((len >> 7) & 1) : 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("o_valid", {63'd0, bus_if.o_valid}, {63'd0, m_valid});
        check("o_sig", {32'd0, bus_if.o_sig}, {32'd0, m_sig});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        bus_if.cfg_we  = 1'b0;
        bus_if.cfg_sel = '0;
        bus_if.cfg_lsb = '0;
        bus_if.cfg_len = '0;
        bus_if.i_valid = 1'b0;
        bus_if.i_bus   = '0;
        bus_if.o_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_o_valid", {63'd0, bus_if.o_valid}, 64'd0);
        check("rst_o_sig", {32'd0, bus_if.o_sig}, 64'd0);
        check("rst_i_ready", {63'd0, bus_if.i_ready}, 64'd1);

        //              r  we sel lsb len   iv w             ordy ev es
        tbl.push_back('{0, 0, 0,  0,  0,    0, 32'h00000000, 1,   0, 32'h00000000});
        tbl.push_back('{0, 0, 0,  0,  0,    1, 32'hA1B2C3D4, 1,   1, 32'hA1B2C3D4});
        tbl.push_back('{0, 1, 0,  28, 8,    0, 32'h00000000, 1,   0, 32'hA1B2C3D4});
        tbl.push_back('{0, 0, 0,  0,  0,    1, 32'hF0000000, 1,   1, 32'hF000000F});
        tbl.push_back('{0, 1, 1,  8,  0,    0, 32'h00000000, 1,   0, 32'hF000000F});
        tbl.push_back('{0, 1, 2,  16, 20,   0, 32'h00000000, 1,   0, 32'hF000000F});
        tbl.push_back('{0, 1, 11, 0,  8,    0, 32'h00000000, 1,   0, 32'hF000000F});
        tbl.push_back('{0, 0, 0,  0,  0,    1, 32'hFF00FF00, 1,   1, 32'hFF00000F});
        tbl.push_back('{1, 0, 0,  0,  0,    0, 32'h00000000, 1,   0, 32'h00000000});
        tbl.push_back('{0, 1, 0,  4,  8,    1, 32'h000000F0, 1,   1, 32'h000000F0});
        tbl.push_back('{0, 0, 0,  0,  0,    1, 32'h000000F0, 1,   1, 32'h0000000F});
        tbl.push_back('{1, 1, 3,  0,  8,    1, 32'h12345678, 1,   0, 32'h00000000});
        tbl.push_back('{0, 0, 0,  0,  0,    1, 32'h12345678, 1,   1, 32'h12345678});
        tbl.push_back('{0, 1, 0,  0,  8'h84, 0, 32'h00000000, 1,  0, 32'h12345678});
        tbl.push_back('{0, 0, 0,  0,  0,    1, 32'h0000000A, 1,   1,
                        SX ? 32'h000000FA : 32'h0000000A});

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].r, tbl[i].we, tbl[i].sel, tbl[i].lsb, tbl[i].len,
                  tbl[i].iv, tbl[i].w, tbl[i].ordy);
            check($sformatf("vec%0d_valid", i), {63'd0, bus_if.o_valid}, {63'd0, tbl[i].ev});
            check($sformatf("vec%0d_sig", i), {32'd0, bus_if.o_sig}, {32'd0, tbl[i].es});
        end

        // Backpressure: held word stays put, pending word enters as the held one drains.
        cycle(0, 0, 0, 0, 0, 1, 32'h11223344, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, 1, 32'h55667788, 0);
            check("stall_i_ready", {63'd0, bus_if.i_ready}, 64'd0);
            check("stall_o_sig", {32'd0, bus_if.o_sig}, {32'd0, 32'h11223344});
        end
        cycle(0, 0, 0, 0, 0, 1, 32'h55667788, 1);
        check("drain_o_sig", {32'd0, bus_if.o_sig}, {32'd0, 32'h55667788});
        cycle(0, 0, 0, 0, 0, 0, 32'h0, 1);
        check("drain_o_valid", {63'd0, bus_if.o_valid}, 64'd0);

        // Reset while a word is held, then confirm the identity mapping is back.
        cycle(0, 1, 1, 0, 3, 1, 32'hCAFEBABE, 0);
        cycle(0, 0, 0, 0, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 0, 0, 0, 32'h0, 0);
        check("rsthold_o_valid", {63'd0, bus_if.o_valid}, 64'd0);
        cycle(0, 0, 0, 0, 0, 1, 32'hA1B2C3D4, 1);
        check("rsthold_defaults", {32'd0, bus_if.o_sig}, {32'd0, 32'hA1B2C3D4});

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 40)),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 1) == 1),
                  $urandom,
                  ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
